// File: rtl/switch_debouncer.sv
`timescale 1us/1ns
// Board-input conditioning: 2-flop synchronisers and per-channel debounce for two
// rate-select switches and an enable button, plus enable toggle and selection-change pulse.
module switch_debouncer #(
  parameter int unsigned DB_CYCLES = 250,
  parameter int unsigned CNT_W     = 14,
  parameter logic        EN_RESET  = 1'b1
) (
  input  logic i_clck,
  input  logic i_rst,
  input  logic i_s1_raw,
  input  logic i_s2_raw,
  input  logic i_btn_raw,
  output logic o_s1,
  output logic o_s2,
  output logic o_enable,
  output logic o_sel_change
);

  localparam int unsigned       NCH  = 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  // Channel order: bit 0 = s1, bit 1 = s2, bit 2 = button.
  logic [NCH-1:0]   w_raw;
  logic [NCH-1:0]   r_sync1;
  logic [NCH-1:0]   r_sync2;
  logic [NCH-1:0]   r_db;
  logic [NCH-1:0]   w_flip;
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [1:0]       r_sel_q;
  logic             r_enable;
  logic             r_sel_change;

  assign w_raw = {i_btn_raw, i_s2_raw, i_s1_raw};

  always_comb begin
    w_flip = '0;
    for (int unsigned i = 0; i < NCH; i++)
      w_flip[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == LAST);
  end

  always_ff @(posedge i_clck or posedge i_rst) begin
    if (i_rst) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_db         <= '0;
      for (int unsigned i = 0; i < NCH; i++)
        r_cnt[i] <= '0;
      r_sel_q      <= '0;
      r_sel_change <= 1'b0;
      r_enable     <= EN_RESET;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      // Toggle on the same edge the debounced button rises.
      if (w_flip[2] && r_sync2[2])
        r_enable <= ~r_enable;
      r_sel_q      <= r_db[1:0];
      r_sel_change <= (r_db[1:0] != r_sel_q);
    end
  end

  assign o_s1         = r_db[0];
  assign o_s2         = r_db[1];
  assign o_enable     = r_enable;
  assign o_sel_change = r_sel_change;

endmodule

// File: tb/tb_switch_debouncer.sv
`timescale 1us/1ns
// Directed and randomized checks of switch_debouncer (DB_CYCLES=4, 40 us clock)
// against a history-based reference model.
module tb_switch_debouncer;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s1_raw = 1'b0, s2_raw = 1'b0, btn_raw = 1'b0;
  logic o_s1, o_s2, o_enable, o_sel_change;

  int n_cmp = 0;
  int n_bad = 0;

  switch_debouncer #(.DB_CYCLES(4), .CNT_W(14), .EN_RESET(1'b1)) dut (
    .i_clck(clk), .i_rst(rst), .i_s1_raw(s1_raw), .i_s2_raw(s2_raw),
    .i_btn_raw(btn_raw), .o_s1(o_s1), .o_s2(o_s2), .o_enable(o_enable),
    .o_sel_change(o_sel_change)
  );

  initial forever #20 clk = ~clk;

  // Reference model: a channel's debounced level flips on edge e when the last DB
  // values it observed (raw sampled two edges earlier) all disagree with it, and
  // all of those observations came after its previous flip or reset release.
  logic [2:0] raw_h[$];
  logic [2:0] m_db;
  int         m_lf[3];
  int         m_e;
  logic       m_en, m_sel, m_pend;

  function automatic logic seen(int j, int c);
    logic [2:0] v;
    if (j < 3) return 1'b0;
    v = raw_h[j-3];
    return v[c];
  endfunction

  task automatic model_reset();
    raw_h.delete();
    m_db = '0; m_e = 0; m_en = 1'b1; m_sel = 1'b0; m_pend = 1'b0;
    for (int c = 0; c < 3; c++) m_lf[c] = 0;
  endtask

  task automatic model_step();
    logic [2:0] flips;
    bit ok;
    if (rst) begin
      model_reset();
      return;
    end
    m_e++;
    raw_h.push_back({btn_raw, s2_raw, s1_raw});
    m_sel = m_pend;
    flips = '0;
    for (int c = 0; c < 3; c++) begin
      ok = (m_e - m_lf[c] >= DB);
      for (int j = m_e - DB + 1; j <= m_e; j++)
        if (seen(j, c) == m_db[c]) ok = 0;
      flips[c] = ok;
    end
    for (int c = 0; c < 3; c++) begin
      if (flips[c]) begin
        if (c == 2 && m_db[2] == 1'b0) m_en = ~m_en;
        m_db[c] = ~m_db[c];
        m_lf[c] = m_e;
      end
    end
    m_pend = flips[0] | flips[1];
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: advance model, then compare all outputs 1 us after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_s1", o_s1, m_db[0]);
    chk("model_s2", o_s2, m_db[1]);
    chk("model_en", o_enable, m_en);
    chk("model_sel", o_sel_change, m_sel);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset mid-cycle, check the asynchronous values, release after n edges.
  task automatic mid_reset(input int n);
    #10;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_s1", o_s1, 1'b0);
    chk("rst_s2", o_s2, 1'b0);
    chk("rst_sel", o_sel_change, 1'b0);
    chk("rst_en", o_enable, 1'b1);
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  int pulses;

  initial begin
    model_reset();
    ticks(3);
    rst = 1'b0;
    ticks(8);

    // Reset with raw inputs high; outputs rise exactly 6 edges after release.
    s1_raw = 1'b1; s2_raw = 1'b1; btn_raw = 1'b1;
    ticks(8);
    chk("pre_rst_s1", o_s1, 1'b1);
    chk("pre_rst_en", o_enable, 1'b0);
    mid_reset(2);
    ticks(5);
    chk("rel_s1_e5", o_s1, 1'b0);
    tick();
    chk("rel_s1_e6", o_s1, 1'b1);
    chk("rel_s2_e6", o_s2, 1'b1);
    tick();
    chk("rel_sel_e7", o_sel_change, 1'b1);
    tick();
    chk("rel_sel_e8", o_sel_change, 1'b0);

    s1_raw = 1'b0; s2_raw = 1'b0; btn_raw = 1'b0;
    mid_reset(2);
    ticks(8);

    // Clean change on s1.
    s1_raw = 1'b1;
    ticks(5);
    chk("clean_s1_e5", o_s1, 1'b0);
    tick();
    chk("clean_s1_e6", o_s1, 1'b1);
    chk("clean_sel_e6", o_sel_change, 1'b0);
    tick();
    chk("clean_sel_e7", o_sel_change, 1'b1);
    chk("clean_s2", o_s2, 1'b0);
    tick();
    chk("clean_sel_e8", o_sel_change, 1'b0);
    ticks(3);

    // Bounce on s2, then hold high.
    s2_raw = 1'b1; tick();
    s2_raw = 1'b0; tick();
    s2_raw = 1'b1; tick();
    s2_raw = 1'b0; tick();
    s2_raw = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 5) chk("bounce_s2_e5", o_s2, 1'b0);
      if (i == 6) chk("bounce_s2_e6", o_s2, 1'b1);
      if (o_sel_change) pulses++;
    end
    chk_n("bounce_pulses", pulses, 1);

    // Button: press, release, press again.
    pulses = 0;
    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) chk("btn1_en_e5", o_enable, 1'b1);
      if (i == 6) chk("btn1_en_e6", o_enable, 1'b0);
      if (o_sel_change) pulses++;
    end
    chk("btn1_en_held", o_enable, 1'b0);
    btn_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("btn_release_en", o_enable, 1'b0);
      if (o_sel_change) pulses++;
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (o_sel_change) pulses++;
    end
    chk("btn2_en", o_enable, 1'b1);
    chk_n("btn_sel_pulses", pulses, 0);
    btn_raw = 1'b0;
    ticks(8);

    // Simultaneous flip of s1 and s2.
    s1_raw = 1'b0; s2_raw = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 5) begin
        chk("simul_s1_e5", o_s1, 1'b1);
        chk("simul_s2_e5", o_s2, 1'b1);
      end
      if (i == 6) begin
        chk("simul_s1_e6", o_s1, 1'b0);
        chk("simul_s2_e6", o_s2, 1'b0);
      end
      if (o_sel_change) pulses++;
    end
    chk_n("simul_pulses", pulses, 1);

    // Reset after three counted cycles discards progress.
    s1_raw = 1'b1;
    ticks(5);
    chk("midcnt_s1_pre", o_s1, 1'b0);
    mid_reset(1);
    chk("midcnt_s1_hold", o_s1, 1'b0);
    ticks(5);
    chk("midcnt_s1_e5", o_s1, 1'b0);
    tick();
    chk("midcnt_s1_e6", o_s1, 1'b1);
    ticks(3);

    // Randomized bouncy inputs with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) s1_raw = ~s1_raw;
      if ($urandom_range(0, 7) == 0) s2_raw = ~s2_raw;
      if ($urandom_range(0, 7) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 499) == 0)
        mid_reset(int'($urandom_range(1, 3)));
      else
        tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
